// File: rtl/hit_scorer.sv
// Scores each lit light exactly once as a hit, miss or wrong press, and keeps the
// saturating score/miss/wrong counters plus the lives counter for the game-over logic.
module hit_scorer #(
    parameter int SCORE_W = 6,
    parameter int LIVES   = 3,
    parameter int LIVES_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clear_i,
    input  logic               enable_i,
    input  logic               use_lives_i,
    input  logic               valid_key_i,
    input  logic [3:0]         key_i,
    input  logic [8:0]         lights_i,
    input  logic [3:0]         light_pos_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] misses_o,
    output logic [SCORE_W-1:0] wrong_o,
    output logic [LIVES_W-1:0] lives_left_o,
    output logic               hit_pulse_o,
    output logic               miss_pulse_o,
    output logic               game_over_o
);

    // state      | meaning
    // IDLE       | scoring disabled, counters hold
    // WAIT_LIGHT | no light armed; any key press is a stray (wrong) press
    // ARMED      | a light is lit at armed_pos and not yet resolved
    // RESOLVED   | current light already hit; further presses ignored
    // DONE       | lives exhausted, everything frozen until clear/reset
    typedef enum logic [2:0] {
        IDLE,
        WAIT_LIGHT,
        ARMED,
        RESOLVED,
        DONE
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_t               state_q, state_d;
    logic [3:0]           armed_pos_q, armed_pos_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   misses_q, misses_d;
    logic [SCORE_W-1:0]   wrong_q, wrong_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic                 game_over_q, game_over_d;
    logic                 valid_key_q, valid_key_d;
    logic                 lit_q, lit_d;

    logic                 lit;
    logic                 key_edge;
    logic                 on_edge;
    logic                 off_edge;
    logic                 pos_chg;
    logic                 hit_ev;
    logic                 wrong_ev;
    logic                 miss_ev;
    logic [LIVES_W:0]     penalty;
    logic [LIVES_W:0]     lives_ext;

    assign lit      = |lights_i;
    assign key_edge = valid_key_i & ~valid_key_q;
    assign on_edge  = lit & ~lit_q;
    assign off_edge = ~lit & lit_q;
    assign pos_chg  = lit && (light_pos_i != armed_pos_q);

    always_comb begin
        state_d     = state_q;
        armed_pos_d = armed_pos_q;
        score_d     = score_q;
        misses_d    = misses_q;
        wrong_d     = wrong_q;
        lives_d     = lives_q;
        game_over_d = game_over_q;
        valid_key_d = valid_key_i;
        lit_d       = lit;
        hit_ev      = 1'b0;
        wrong_ev    = 1'b0;
        miss_ev     = 1'b0;
        penalty     = '0;
        lives_ext   = {1'b0, lives_q};

        case (state_q)
            IDLE: begin
                if (enable_i) state_d = WAIT_LIGHT;
            end
            WAIT_LIGHT: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else begin
                    if (on_edge) begin
                        state_d     = ARMED;
                        armed_pos_d = light_pos_i;
                    end
                    wrong_ev = key_edge;
                end
            end
            ARMED: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else begin
                    // Key is judged against the position armed before this edge,
                    // so a correct press coinciding with the light going off still hits.
                    hit_ev   = key_edge && (key_i == armed_pos_q);
                    wrong_ev = key_edge && !hit_ev;
                    miss_ev  = !hit_ev && (off_edge || pos_chg);
                    if (off_edge) begin
                        state_d = WAIT_LIGHT;
                    end else if (pos_chg) begin
                        armed_pos_d = light_pos_i;
                    end else if (hit_ev) begin
                        state_d = RESOLVED;
                    end
                end
            end
            RESOLVED: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (off_edge) begin
                    state_d = WAIT_LIGHT;
                end else if (pos_chg) begin
                    state_d     = ARMED;
                    armed_pos_d = light_pos_i;
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase

        if (hit_ev && (score_q != SCORE_MAX))    score_d  = score_q + 1'b1;
        if (wrong_ev && (wrong_q != SCORE_MAX))  wrong_d  = wrong_q + 1'b1;
        if (miss_ev && (misses_q != SCORE_MAX))  misses_d = misses_q + 1'b1;

        penalty = (LIVES_W+1)'(wrong_ev) + (LIVES_W+1)'(miss_ev);
        if (use_lives_i && (penalty != '0)) begin
            if (lives_ext > penalty) begin
                lives_d = LIVES_W'(lives_ext - penalty);
            end else begin
                lives_d     = '0;
                game_over_d = 1'b1;
                state_d     = DONE;
            end
        end

        hit_d  = hit_ev;
        miss_d = wrong_ev | miss_ev;

        if (clear_i) begin
            state_d     = IDLE;
            armed_pos_d = '0;
            score_d     = '0;
            misses_d    = '0;
            wrong_d     = '0;
            lives_d     = LIVES_INIT;
            game_over_d = 1'b0;
            hit_d       = 1'b0;
            miss_d      = 1'b0;
            valid_key_d = 1'b0;
            lit_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            armed_pos_q <= '0;
            score_q     <= '0;
            misses_q    <= '0;
            wrong_q     <= '0;
            lives_q     <= LIVES_INIT;
            game_over_q <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            valid_key_q <= 1'b0;
            lit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_pos_q <= armed_pos_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            wrong_q     <= wrong_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            valid_key_q <= valid_key_d;
            lit_q       <= lit_d;
        end
    end

    assign score_o      = score_q;
    assign misses_o     = misses_q;
    assign wrong_o      = wrong_q;
    assign lives_left_o = lives_q;
    assign hit_pulse_o  = hit_q;
    assign miss_pulse_o = miss_q;
    assign game_over_o  = game_over_q;

endmodule
